// File: rtl/wb_decoded_bus.sv
// ---------------------------------------------------------------------------
// wb_decoded_bus
//
// Single-master Wishbone fabric. It decodes the master byte address against
// per-slave inclusive {base, last} ranges and forwards one registered
// transaction at a time to the selected slave. Unmapped addresses, slave
// errors and slaves that stay silent too long all end in a bus error. The
// address and cause of the most recent error are kept for software, and a
// one-cycle interrupt pulse is raised with each error.
//
// Parameters
//   N           number of slave ports (1..16)
//   ADDR_RANGES {base, last} pair per slave, slave 0 first; lowest index
//               wins when ranges overlap
//   TIMEOUT     max ACTIVE cycles before a timeout error; 0 disables it
//
// Ports
//   clk_in, reset_in            clock, synchronous active-high reset
//   m_cyc_in/m_stb_in/m_we_in   master cycle, strobe, write
//   m_adr_in/m_dat_in/m_sel_in  master address, write data, byte selects
//   m_dat_out                   read data, valid with m_ack_out
//   m_ack_out/m_err_out         one-cycle termination pulses
//   s_adr_out/s_dat_out         registered address/write data (broadcast)
//   s_sel_out/s_we_out          registered byte selects / write
//   s_cyc_out/s_stb_out         one-hot per-slave cycle/strobe
//   s_dat_in/s_ack_in/s_err_in  slave read data and terminations
//   err_irq_out                 pulse on any error termination
//   err_addr_out/err_cause_out  last errored address and its cause
//                               (01 unmapped, 10 timeout, 11 slave error)
// ---------------------------------------------------------------------------
module wb_decoded_bus #(
   parameter int N = 4,
   parameter logic [0:2*N-1][31:0] ADDR_RANGES = {
      32'h0000_0000, 32'h0000_2FFC,
      32'h0000_3000, 32'h0000_3FFC,
      32'h0000_4000, 32'h0000_4000,
      32'h0000_4010, 32'h0000_401C},
   parameter int TIMEOUT = 255
) (
   input  logic            clk_in,
   input  logic            reset_in,
   input  logic            m_cyc_in,
   input  logic            m_stb_in,
   input  logic            m_we_in,
   input  logic [31:0]     m_adr_in,
   input  logic [31:0]     m_dat_in,
   input  logic [3:0]      m_sel_in,
   output logic [31:0]     m_dat_out,
   output logic            m_ack_out,
   output logic            m_err_out,
   output logic [31:0]     s_adr_out,
   output logic [31:0]     s_dat_out,
   output logic [3:0]      s_sel_out,
   output logic            s_we_out,
   output logic [N-1:0]    s_cyc_out,
   output logic [N-1:0]    s_stb_out,
   input  logic [32*N-1:0] s_dat_in,
   input  logic [N-1:0]    s_ack_in,
   input  logic [N-1:0]    s_err_in,
   output logic            err_irq_out,
   output logic [31:0]     err_addr_out,
   output logic [1:0]      err_cause_out
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      RESP
   } state_t;

   state_t          state;
   logic [IW-1:0]   sel_idx;
   logic [CW-1:0]   tmo_cnt;

   logic            dec_hit;
   logic [IW-1:0]   dec_idx;
   logic            sel_ack;
   logic            sel_err;
   logic [31:0]     sel_dat;
   logic            tmo_hit;

   // Address decode of the live master address. Scanning from the top index
   // down lets the lowest matching slave overwrite any higher match, which
   // gives lowest-index priority on overlapping ranges.
   always_comb begin
      dec_hit = 1'b0;
      dec_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if ((m_adr_in >= ADDR_RANGES[2*i]) && (m_adr_in <= ADDR_RANGES[2*i+1])) begin
            dec_hit = 1'b1;
            dec_idx = IW'(i);
         end
      end
   end

   // Pick out the terminations and read data of the latched slave only, so
   // anything the other slaves do on their lines has no effect.
   always_comb begin
      sel_ack = 1'b0;
      sel_err = 1'b0;
      sel_dat = '0;
      for (int i = 0; i < N; i++) begin
         if (sel_idx == IW'(i)) begin
            sel_ack = s_ack_in[i];
            sel_err = s_err_in[i];
            sel_dat = s_dat_in[32*i +: 32];
         end
      end
   end

   // The counter holds the number of ACTIVE cycles already completed, so the
   // timeout fires at the end of ACTIVE cycle TIMEOUT.
   always_comb begin
      tmo_hit = (TIMEOUT > 0) && ((int'(tmo_cnt) + 1) == TIMEOUT);
   end

   // Main transaction FSM. Every output is a register: termination pulses and
   // read data are loaded on the edge that enters RESP and cleared on the edge
   // that leaves it; slave strobes are loaded entering ACTIVE and cleared on
   // any exit from ACTIVE (termination, timeout, abort or reset).
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state         <= IDLE;
         sel_idx       <= '0;
         tmo_cnt       <= '0;
         m_dat_out     <= '0;
         m_ack_out     <= 1'b0;
         m_err_out     <= 1'b0;
         s_adr_out     <= '0;
         s_dat_out     <= '0;
         s_sel_out     <= '0;
         s_we_out      <= 1'b0;
         s_cyc_out     <= '0;
         s_stb_out     <= '0;
         err_irq_out   <= 1'b0;
         err_addr_out  <= '0;
         err_cause_out <= 2'b00;
      end else begin
         m_ack_out   <= 1'b0;
         m_err_out   <= 1'b0;
         err_irq_out <= 1'b0;
         m_dat_out   <= '0;

         case (state)
            IDLE: begin
               if (m_cyc_in && m_stb_in) begin
                  s_adr_out <= m_adr_in;
                  s_dat_out <= m_dat_in;
                  s_sel_out <= m_sel_in;
                  s_we_out  <= m_we_in;
                  if (dec_hit) begin
                     sel_idx   <= dec_idx;
                     tmo_cnt   <= '0;
                     s_cyc_out <= N'(1) << dec_idx;
                     s_stb_out <= N'(1) << dec_idx;
                     state     <= ACTIVE;
                  end else begin
                     m_err_out     <= 1'b1;
                     err_irq_out   <= 1'b1;
                     err_addr_out  <= m_adr_in;
                     err_cause_out <= 2'b01;
                     state         <= RESP;
                  end
               end
            end

            ACTIVE: begin
               // A master abort wins over everything: the master is no
               // longer listening, so nothing is reported or logged.
               if (!m_cyc_in) begin
                  s_cyc_out <= '0;
                  s_stb_out <= '0;
                  state     <= IDLE;
               end else if (sel_ack) begin
                  s_cyc_out <= '0;
                  s_stb_out <= '0;
                  m_ack_out <= 1'b1;
                  m_dat_out <= s_we_out ? 32'h0 : sel_dat;
                  state     <= RESP;
               end else if (sel_err) begin
                  s_cyc_out     <= '0;
                  s_stb_out     <= '0;
                  m_err_out     <= 1'b1;
                  err_irq_out   <= 1'b1;
                  err_addr_out  <= s_adr_out;
                  err_cause_out <= 2'b11;
                  state         <= RESP;
               end else if (tmo_hit) begin
                  s_cyc_out     <= '0;
                  s_stb_out     <= '0;
                  m_err_out     <= 1'b1;
                  err_irq_out   <= 1'b1;
                  err_addr_out  <= s_adr_out;
                  err_cause_out <= 2'b10;
                  state         <= RESP;
               end else if (tmo_cnt != '1) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            RESP: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/wb_decoded_bus.md
# wb_decoded_bus

Parametrised single-master Wishbone bus fabric connecting the CPU core's bus master to N memory-mapped slaves (program memory, data memory, LED controller, external IRQ controller, and future peripherals). It decodes the master address against per-slave inclusive ranges and forwards one registered transaction at a time. Unlike the plain interconnect, it returns a bus error for unmapped addresses and for slaves that do not respond within a timeout. It also latches error information for software and raises an error interrupt.

## Interface
- N, 4, number of slave ports (1..16)
- ADDR_RANGES, {0,'h2FFC,'h3000,'h3FFC,'h4000,'h4000,'h4010,'h401C}, 2N x 32-bit words {base, last} per slave, inclusive, word-aligned; lowest index wins on overlap
- TIMEOUT, 255, max ACTIVE cycles before timeout error; 0 disables timeout

- clk_in  in  1  system clock
- reset_in  in  1  synchronous, active-high reset
- m_cyc_in, m_stb_in, m_we_in  in  1  master cycle/strobe/write
- m_adr_in  in  32  master byte address
- m_dat_in  in  32  master write data
- m_sel_in  in  4  byte selects
- m_dat_out  out  32  read data, valid with m_ack_out
- m_ack_out, m_err_out  out  1  one-cycle termination pulses (mutually exclusive)
- s_adr_out, s_dat_out  out  32  registered address/write data, broadcast to all slaves
- s_sel_out  out  4  registered byte selects; s_we_out out 1 registered write
- s_cyc_out, s_stb_out  out  N  one-hot per-slave cycle/strobe
- s_dat_in  in  32*N  slave read data, slave i at [32i+31:32i]
- s_ack_in, s_err_in  in  N  slave terminations
- err_irq_out  out  1  one-cycle pulse on any error termination
- err_addr_out  out  32  address of most recent errored access
- err_cause_out  out  2  01 unmapped, 10 timeout, 11 slave err, 00 none since reset

## Operation
- FSM states IDLE, ACTIVE, RESP.
- IDLE: when m_cyc_in&m_stb_in are sampled high, register adr/dat/sel/we and decode. Match means base <= adr <= last.
  - Hit at slave k: latch index k, clear timeout counter, go to ACTIVE.
  - Miss: go to RESP with error, cause 01.
- ACTIVE: drive s_cyc_out[k]=s_stb_out[k]=1; all other bits 0.
  - s_ack_in[k] sampled: latch s_dat_in slice k, go to RESP with ack.
  - s_err_in[k] sampled: RESP with error, cause 11; ack takes priority if both are high.
  - Counter reaches TIMEOUT (TIMEOUT>0) with no termination: drop slave cyc/stb, RESP with error, cause 10.
  - m_cyc_in sampled low (abort): drop slave cyc/stb, return to IDLE, no response, no error logged.
  - Termination inputs from non-selected slaves are ignored.
- RESP: assert exactly one of m_ack_out/m_err_out for one cycle, then return to IDLE.
  - m_dat_out holds latched read data on ack and 0 on error.
  - On error, in the same cycle: err_irq_out=1, err_addr_out<=registered address, err_cause_out<=cause.
- Writes and reads share the same path. Read data is 0 for write acks.
- Timeout counter: $clog2(TIMEOUT+1) bits, saturating, active only in ACTIVE.

## Timing
- Reset (synchronous): state IDLE; all outputs 0, including s_adr/s_dat/s_sel/s_we, err_addr_out and err_cause_out.
- Reset asserted mid-transaction: at the next edge all slave strobes drop and no ack/err is issued.
- Best case, with slave acking in its first ACTIVE cycle: master strobe in cycle 0, slave strobe in cycle 1, m_ack_out in cycle 2.
- Unmapped access: m_err_out in cycle 1.
- Timeout: slave strobe in cycles 1..TIMEOUT, m_err_out in cycle TIMEOUT+1.
- A new request may be sampled in the first IDLE cycle after RESP, one cycle after the master's ack.
- The master must hold stb/adr/dat stable until termination. Values are registered once in IDLE; later changes are ignored.
- Address boundaries: adr==last matches. adr==last+4 falls to the next range or is unmapped. adr 'hFFFFFFFC is unmapped by default.

## Test plan
- Read at 'h3004 with slave 1 acking in its first cycle with 'hDEADBEEF → s_stb_out=4'b0010 in cycle 1; m_ack_out with m_dat_out='hDEADBEEF in cycle 2; err_irq_out stays 0.
- Write at 'h4008 (unmapped gap) → no s_stb_out bit set; m_err_out in cycle 1; err_irq_out pulses once; err_addr_out='h4008; err_cause_out=01.
- Read at 'h4010 with slave 3 never acking, TIMEOUT=8 → s_stb_out[3] high for exactly 8 cycles; m_err_out in cycle 9; cause 10.
- Slave 2 asserts s_err_in and s_ack_in together, then slave 2 asserts s_err_in alone → first access gets m_ack_out; second gets m_err_out with cause 11.
- Master drops m_cyc_in in cycle 2 of an ACTIVE access to slave 0 → slave strobe low from cycle 3; no m_ack_out/m_err_out; err outputs unchanged.
- reset_in asserted in an ACTIVE cycle → next cycle all outputs 0 and state IDLE. A subsequent access at 'h2FFC then completes normally on slave 0.
